// File: rtl/ofdm_mixer_pkg.sv
// Shared constants and helpers for the NCO complex mixer.
// Holds default widths, mix-mode codes, FSM codes and rounding/clip helpers.
package ofdm_mixer_pkg;

    localparam int DW_DEF  = 16;
    localparam int MPR_DEF = 16;

    localparam logic MIX_UP   = 1'b0;
    localparam logic MIX_DOWN = 1'b1;

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Half an LSB of the Q(MPR-1) product, for round-half-up.
    function automatic longint rnd_const(input int mpr);
        return longint'(1) <<< (mpr - 2);
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/ofdm_cmult_rs.sv
// Complex multiply with round/saturate: products, add/sub, round+clip.
// Ports: i_en global advance, i_valid/i_last/i_conj + operands in, o_* result.
module ofdm_cmult_rs
    import ofdm_mixer_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int MPR = MPR_DEF
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic                  i_last,
    input  logic                  i_conj,
    input  logic signed [DW-1:0]  i_xi,
    input  logic signed [DW-1:0]  i_xq,
    input  logic signed [MPR-1:0] i_c,
    input  logic signed [MPR-1:0] i_s,
    output logic                  o_valid,
    output logic                  o_last,
    output logic                  o_sat,
    output logic signed [DW-1:0]  o_i,
    output logic signed [DW-1:0]  o_q
);

    localparam int PW = DW + MPR;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(rnd_const(MPR));
    localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DW));
    localparam logic signed [SW-1:0] MINV = SW'(sat_min(DW));

    logic signed [PW-1:0] r_ic, r_qs, r_is, r_qc;
    logic                 r_v2, r_l2, r_cj2;
    logic signed [SW-1:0] r_yi, r_yq;
    logic                 r_v3, r_l3;

    logic signed [SW-1:0] w_ri, w_rq;
    logic signed [DW-1:0] w_oi, w_oq;
    logic                 w_sat_i, w_sat_q;

    // S2: full-precision products
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_v2  <= 1'b0;
            r_l2  <= 1'b0;
            r_cj2 <= 1'b0;
            r_ic  <= '0;
            r_qs  <= '0;
            r_is  <= '0;
            r_qc  <= '0;
        end else if (i_en) begin
            r_v2  <= i_valid;
            r_l2  <= i_last;
            r_cj2 <= i_conj;
            r_ic  <= PW'(i_xi) * PW'(i_c);
            r_qs  <= PW'(i_xq) * PW'(i_s);
            r_is  <= PW'(i_xi) * PW'(i_s);
            r_qc  <= PW'(i_xq) * PW'(i_c);
        end
    end

    // S3: one guard bit absorbs the sum growth
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_v3 <= 1'b0;
            r_l3 <= 1'b0;
            r_yi <= '0;
            r_yq <= '0;
        end else if (i_en) begin
            r_v3 <= r_v2;
            r_l3 <= r_l2;
            if (r_cj2 == MIX_DOWN) begin
                r_yi <= SW'(r_ic) + SW'(r_qs);
                r_yq <= SW'(r_qc) - SW'(r_is);
            end else begin
                r_yi <= SW'(r_ic) - SW'(r_qs);
                r_yq <= SW'(r_is) + SW'(r_qc);
            end
        end
    end

    // S4 combinational: round half up, then clip to DW
    assign w_ri = (r_yi + RND) >>> (MPR - 1);
    assign w_rq = (r_yq + RND) >>> (MPR - 1);

    always_comb begin
        w_oi    = w_ri[DW-1:0];
        w_sat_i = 1'b0;
        if (w_ri > MAXV) begin
            w_oi    = MAXV[DW-1:0];
            w_sat_i = 1'b1;
        end else if (w_ri < MINV) begin
            w_oi    = MINV[DW-1:0];
            w_sat_i = 1'b1;
        end
    end

    always_comb begin
        w_oq    = w_rq[DW-1:0];
        w_sat_q = 1'b0;
        if (w_rq > MAXV) begin
            w_oq    = MAXV[DW-1:0];
            w_sat_q = 1'b1;
        end else if (w_rq < MINV) begin
            w_oq    = MINV[DW-1:0];
            w_sat_q = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_sat   <= 1'b0;
            o_i     <= '0;
            o_q     <= '0;
        end else if (i_en) begin
            o_valid <= r_v3;
            o_last  <= r_l3;
            o_sat   <= w_sat_i | w_sat_q;
            o_i     <= w_oi;
            o_q     <= w_oq;
        end
    end

endmodule

// File: rtl/ofdm_nco_mixer.sv
// Frequency-shift stage: pairs each I/Q sample with one NCO sin/cos word.
// Ports: s_* input stream, nco_* NCO link, m_* output stream, status/clear.
module ofdm_nco_mixer
    import ofdm_mixer_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int MPR = MPR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [DW-1:0]  s_i,
    input  logic signed [DW-1:0]  s_q,
    input  logic                  s_last,
    input  logic                  conj_i,
    input  logic signed [MPR-1:0] nco_sin,
    input  logic signed [MPR-1:0] nco_cos,
    input  logic                  nco_valid,
    output logic                  nco_clken,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [DW-1:0]  m_i,
    output logic signed [DW-1:0]  m_q,
    output logic                  m_last,
    output logic                  m_sat,
    output logic                  primed_o,
    output logic                  sat_sticky_o,
    input  logic                  clr_i
);

    logic w_pipe_en, w_fire;
    logic [0:0] r_state, w_state_nxt;

    logic                  r_v1, r_l1, r_cj1;
    logic signed [DW-1:0]  r_xi, r_xq;
    logic signed [MPR-1:0] r_c, r_s;

    // Whole pipeline freezes while the output word is blocked.
    assign w_pipe_en = !(m_valid && !m_ready);
    assign w_fire    = s_valid && nco_valid && w_pipe_en;
    assign s_ready   = nco_valid && w_pipe_en;
    // Free-run the NCO until it is valid, then step once per consumed sample.
    assign nco_clken = !nco_valid || w_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_l1  <= 1'b0;
            r_cj1 <= 1'b0;
            r_xi  <= '0;
            r_xq  <= '0;
            r_c   <= '0;
            r_s   <= '0;
        end else if (w_pipe_en) begin
            r_v1 <= w_fire;
            if (w_fire) begin
                r_l1  <= s_last;
                r_cj1 <= conj_i;
                r_xi  <= s_i;
                r_xq  <= s_q;
                r_c   <= nco_cos;
                r_s   <= nco_sin;
            end
        end
    end

    ofdm_cmult_rs #(
        .DW  (DW),
        .MPR (MPR)
    ) u_cmult (
        .clk     (clk),
        .i_rst   (reset),
        .i_en    (w_pipe_en),
        .i_valid (r_v1),
        .i_last  (r_l1),
        .i_conj  (r_cj1),
        .i_xi    (r_xi),
        .i_xq    (r_xq),
        .i_c     (r_c),
        .i_s     (r_s),
        .o_valid (m_valid),
        .o_last  (m_last),
        .o_sat   (m_sat),
        .o_i     (m_i),
        .o_q     (m_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_PRIME: if (nco_valid)  w_state_nxt = ST_RUN;
            ST_RUN:   if (!nco_valid) w_state_nxt = ST_PRIME;
            default:  w_state_nxt = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_PRIME;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign primed_o = (r_state == ST_RUN);

    // A new saturation event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_sticky_o <= 1'b0;
        end else if (m_valid && m_ready && m_sat) begin
            sat_sticky_o <= 1'b1;
        end else if (clr_i) begin
            sat_sticky_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofdm_nco_mixer.sv
// Directed testbench for ofdm_nco_mixer.
// Each scenario task drives vectors and checks results inline.
module tb_ofdm_nco_mixer;
    import ofdm_mixer_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid, s_ready, s_last, conj_i;
    logic signed [15:0] s_i, s_q;
    logic signed [15:0] nco_sin, nco_cos;
    logic               nco_valid, nco_clken;
    logic               m_valid, m_ready, m_last, m_sat;
    logic signed [15:0] m_i, m_q;
    logic               primed_o, sat_sticky_o, clr_i;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ofdm_nco_mixer dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .s_last       (s_last),
        .conj_i       (conj_i),
        .nco_sin      (nco_sin),
        .nco_cos      (nco_cos),
        .nco_valid    (nco_valid),
        .nco_clken    (nco_clken),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_i          (m_i),
        .m_q          (m_q),
        .m_last       (m_last),
        .m_sat        (m_sat),
        .primed_o     (primed_o),
        .sat_sticky_o (sat_sticky_o),
        .clr_i        (clr_i)
    );

    // Reference arithmetic in 64-bit integers.
    function automatic void model(input int xi, xq, c, sn, input bit cj,
                                  output int yi, yq, output bit st);
        longint ai, aq;
        bit     si, sq;
        if (cj) begin
            ai = longint'(xi) * c + longint'(xq) * sn;
            aq = longint'(xq) * c - longint'(xi) * sn;
        end else begin
            ai = longint'(xi) * c - longint'(xq) * sn;
            aq = longint'(xi) * sn + longint'(xq) * c;
        end
        ai = (ai + 16384) >>> 15;
        aq = (aq + 16384) >>> 15;
        si = 1'b0;
        sq = 1'b0;
        if (ai > 32767) begin ai = 32767; si = 1'b1; end
        else if (ai < -32768) begin ai = -32768; si = 1'b1; end
        if (aq > 32767) begin aq = 32767; sq = 1'b1; end
        else if (aq < -32768) begin aq = -32768; sq = 1'b1; end
        yi = int'(ai);
        yq = int'(aq);
        st = si | sq;
    endfunction

    task automatic drive(input int xi, xq, c, sn, input bit cj, lst, vld);
        s_i       = 16'(xi);
        s_q       = 16'(xq);
        nco_cos   = 16'(c);
        nco_sin   = 16'(sn);
        conj_i    = cj;
        s_last    = lst;
        s_valid   = vld;
        nco_valid = 1'b1;
    endtask

    // Fire one sample, return at the negedge where its result is shown.
    task automatic push(input int xi, xq, c, sn, input bit cj, lst);
        @(negedge clk);
        drive(xi, xq, c, sn, cj, lst, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({m_valid, m_last, m_sat, sat_sticky_o, primed_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {m_valid, m_last, m_sat, sat_sticky_o, primed_o});
        end
        n_chk++;
        if ({m_i, m_q} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d,%0d want 0,0", m_i, m_q);
        end
        n_chk++;
        if (nco_clken !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clken: got %b want 1", nco_clken);
        end
    endtask

    task automatic test_priming;
        reset   = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_chk++;
            if (nco_clken !== 1'b1 || s_ready !== 1'b0 || primed_o !== 1'b0) begin
                n_fail++;
                $display("FAIL prime_cyc%0d: clken=%b ready=%b primed=%b want 1,0,0",
                         k, nco_clken, s_ready, primed_o);
            end
        end
        @(negedge clk);
        s_valid   = 1'b0;
        nco_valid = 1'b1;
        #1;
        n_chk++;
        if (primed_o !== 1'b0 || nco_clken !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_edge: primed=%b clken=%b want 0,0", primed_o, nco_clken);
        end
        @(negedge clk);
        n_chk++;
        if (primed_o !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL prime_done: primed=%b m_valid=%b want 1,0", primed_o, m_valid);
        end
    endtask

    task automatic test_unity;
        @(negedge clk);
        drive(16384, 0, 32767, 0, MIX_UP, 1'b0, 1'b1);
        #1;
        n_chk++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL unity_fire: s_ready=%b want 1", s_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if (k < 4) begin
                n_chk++;
                if (m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unity_early%0d: m_valid=%b want 0", k, m_valid);
                end
            end
        end
        n_chk++;
        if (m_valid !== 1'b1 || m_i !== 16'sd16384 || m_q !== 16'sd0 || m_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL unity_out: v=%b i=%0d q=%0d sat=%b want 1,16384,0,0",
                     m_valid, m_i, m_q, m_sat);
        end
    endtask

    task automatic test_saturation;
        push(32767, 32767, 23170, 23170, MIX_DOWN, 1'b0);
        n_chk++;
        if (m_valid !== 1'b1 || m_i !== 16'sd32767 || m_q !== 16'sd0 || m_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_down: v=%b i=%0d q=%0d sat=%b want 1,32767,0,1",
                     m_valid, m_i, m_q, m_sat);
        end
        push(32767, 32767, 23170, 23170, MIX_UP, 1'b0);
        n_chk++;
        if (m_valid !== 1'b1 || m_i !== 16'sd0 || m_q !== 16'sd32767 || m_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_up: v=%b i=%0d q=%0d sat=%b want 1,0,32767,1",
                     m_valid, m_i, m_q, m_sat);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (sat_sticky_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_hold: got %b want 1", sat_sticky_o);
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        n_chk++;
        if (sat_sticky_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_clr: got %b want 0", sat_sticky_o);
        end
        push(32767, 32767, 23170, 23170, MIX_UP, 1'b0);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        n_chk++;
        if (sat_sticky_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_set_wins: got %b want 1", sat_sticky_o);
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic test_corner;
        push(-32768, -32768, -32768, 0, MIX_UP, 1'b1);
        n_chk++;
        if (m_i !== 16'sd32767 || m_q !== 16'sd32767 || m_sat !== 1'b1 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL corner: i=%0d q=%0d sat=%b last=%b want 32767,32767,1,1",
                     m_i, m_q, m_sat, m_last);
        end
        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic test_backpressure;
        int xi[20], xq[20], cc[20], ss[20];
        bit cj[20], ls[20];
        int ei, eq;
        bit es;
        int idx = 0;
        int got = 0;
        int pulses = 0;
        bit fired = 1'b0;
        bit stalled = 1'b0;
        logic [33:0] held = '0;
        for (int k = 0; k < 20; k++) begin
            xi[k] = int'($urandom_range(0, 65535)) - 32768;
            xq[k] = int'($urandom_range(0, 65535)) - 32768;
            cc[k] = int'($urandom_range(0, 65535)) - 32768;
            ss[k] = int'($urandom_range(0, 65535)) - 32768;
            cj[k] = 1'($urandom_range(0, 1));
            ls[k] = (k % 5 == 4);
        end
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            if (fired) idx++;
            if (stalled) begin
                n_chk++;
                if ({m_i, m_q, m_last, m_sat} !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %h want %h", {m_i, m_q, m_last, m_sat}, held);
                end
            end
            m_ready = 1'($urandom_range(0, 1));
            if (idx < 20) drive(xi[idx], xq[idx], cc[idx], ss[idx], cj[idx], ls[idx], 1'b1);
            else s_valid = 1'b0;
            #1;
            fired = s_valid && s_ready;
            if (nco_clken) pulses++;
            stalled = m_valid && !m_ready;
            if (stalled) begin
                held = {m_i, m_q, m_last, m_sat};
                n_chk++;
                if (s_ready !== 1'b0 || nco_clken !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall: ready=%b clken=%b want 0,0", s_ready, nco_clken);
                end
            end
            if (m_valid && m_ready) begin
                model(xi[got], xq[got], cc[got], ss[got], cj[got], ei, eq, es);
                n_chk++;
                if (m_i !== 16'(ei) || m_q !== 16'(eq) || m_sat !== es || m_last !== ls[got]) begin
                    n_fail++;
                    $display("FAIL bp_out%0d: got %0d,%0d,%b,%b want %0d,%0d,%b,%b",
                             got, m_i, m_q, m_sat, m_last, ei, eq, es, ls[got]);
                end
                got++;
            end
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        n_chk++;
        if (got != 20 || pulses != 20) begin
            n_fail++;
            $display("FAIL bp_count: outputs=%0d clken_pulses=%0d want 20,20", got, pulses);
        end
        repeat (6) @(negedge clk);
        n_chk++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_extra: m_valid=%b want 0", m_valid);
        end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic test_midreset;
        int outs = 0;
        m_ready = 1'b1;
        @(negedge clk);
        drive(100, 200, 32767, 0, MIX_UP, 1'b1, 1'b1);
        @(negedge clk);
        drive(300, 400, 32767, 0, MIX_UP, 1'b0, 1'b1);
        @(negedge clk);
        drive(500, 600, 32767, 0, MIX_UP, 1'b1, 1'b1);
        @(negedge clk);
        drive(700, 800, 32767, 0, MIX_UP, 1'b0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        n_chk++;
        if (m_valid !== 1'b1 || m_i !== 16'sd100 || m_q !== 16'sd200 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_pre: v=%b i=%0d q=%0d last=%b want 1,100,200,1",
                     m_valid, m_i, m_q, m_last);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({m_valid, m_last, m_sat, primed_o} !== 4'b0 || {m_i, m_q} !== 32'h0) begin
            n_fail++;
            $display("FAIL mr_async: v=%b last=%b sat=%b primed=%b i=%0d q=%0d want zeros",
                     m_valid, m_last, m_sat, primed_o, m_i, m_q);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(1000, -2000, 16384, 8192, MIX_UP, 1'b0, 1'b1);
        @(negedge clk);
        drive(-4096, 4096, 0, 32767, MIX_DOWN, 1'b1, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (m_valid) begin
                n_chk++;
                if (outs == 0) begin
                    if (m_i !== 16'sd1000 || m_q !== -16'sd750 || m_last !== 1'b0) begin
                        n_fail++;
                        $display("FAIL mr_first: got %0d,%0d,%b want 1000,-750,0",
                                 m_i, m_q, m_last);
                    end
                end else if (outs == 1) begin
                    if (m_i !== 16'sd4096 || m_q !== 16'sd4096 || m_last !== 1'b1) begin
                        n_fail++;
                        $display("FAIL mr_second: got %0d,%0d,%b want 4096,4096,1",
                                 m_i, m_q, m_last);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL mr_extra: output %0d got %0d,%0d want none",
                             outs, m_i, m_q);
                end
                outs++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (outs != 2) begin
            n_fail++;
            $display("FAIL mr_count: got %0d want 2", outs);
        end
    endtask

    initial begin
        reset     = 1'b1;
        s_valid   = 1'b0;
        s_i       = '0;
        s_q       = '0;
        s_last    = 1'b0;
        conj_i    = 1'b0;
        nco_sin   = '0;
        nco_cos   = '0;
        nco_valid = 1'b0;
        m_ready   = 1'b1;
        clr_i     = 1'b0;
        test_reset();
        test_priming();
        test_unity();
        test_saturation();
        test_corner();
        test_backpressure();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
